// File: rtl/game_pkg.sv
// Shared game constants and the bullet FSM state type, used by the bullet
// controller, renderer and collision checker.
package game_pkg;

  localparam int H_ACTIVE  = 800;
  localparam int V_ACTIVE  = 600;
  localparam int R_DEFAULT = 12;

  localparam int XW = 11;
  localparam int YW = 10;
  localparam int CW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    COOL = 2'd2
  } bullet_state_e;

endpackage

// File: rtl/bullet_ctrl_if.sv
// Bullet controller bundle: player/collision inputs and the position/valid
// outputs consumed by the renderer.
interface bullet_ctrl_if;
  import game_pkg::*;

  logic          fire;
  logic          frame_tick;
  logic          hit;
  logic [XW-1:0] shooter_x;
  logic [YW-1:0] shooter_y;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          active;
  logic          launched;

  modport master (
    input  fire, frame_tick, hit, shooter_x, shooter_y,
    output x, y, active, launched
  );

  modport slave (
    output fire, frame_tick, hit, shooter_x, shooter_y,
    input  x, y, active, launched
  );

endinterface

// File: rtl/rise_detect.sv
// Registered rising-edge detector for a level input already synchronous to clk.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/bullet_ctrl.sv
// Single-bullet motion controller: launch on fire edge, fly upward one step
// per frame, retire on hit or top edge, then enforce a frame-counted cooldown.
module bullet_ctrl
  import game_pkg::*;
#(
  parameter int R        = R_DEFAULT,
  parameter int SPEED    = 6,
  parameter int COOLDOWN = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  bullet_ctrl_if.master bus
);

  localparam logic [YW-1:0] Y_RETIRE  = YW'(R + SPEED);
  localparam logic [YW-1:0] Y_STEP    = YW'(SPEED);
  localparam logic [CW-1:0] COOL_INIT = CW'(COOLDOWN);
  localparam logic [XW-1:0] X_MAX     = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_MAX     = YW'(V_ACTIVE - 1);

  bullet_state_e state_q, state_d;

  logic          fire_rise;
  logic          retire;
  logic [XW-1:0] x_q, x_d, launch_x;
  logic [YW-1:0] y_q, y_d, launch_y;
  logic [CW-1:0] cool_cnt_q, cool_cnt_d;
  logic          active_q, active_d;
  logic          launched_q, launched_d;

  rise_detect u_fire_rise (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.fire),
    .rise (fire_rise)
  );

  assign launch_x = (bus.shooter_x > X_MAX) ? X_MAX : bus.shooter_x;
  assign launch_y = (bus.shooter_y > Y_MAX) ? Y_MAX : bus.shooter_y;

  // Compare before subtracting so y can never wrap past the top edge.
  assign retire = bus.hit | (bus.frame_tick & (y_q < Y_RETIRE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fire_rise)          state_d = FLY;
      FLY:     if (retire)             state_d = COOL;
      COOL:    if (cool_cnt_q == '0)   state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    cool_cnt_d = cool_cnt_q;
    active_d   = active_q;
    launched_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fire_rise) begin
          x_d        = launch_x;
          y_d        = launch_y;
          active_d   = 1'b1;
          launched_d = 1'b1;
        end
      end
      FLY: begin
        if (retire) begin
          active_d   = 1'b0;
          cool_cnt_d = COOL_INIT;
        end else if (bus.frame_tick) begin
          y_d = y_q - Y_STEP;
        end
      end
      COOL: begin
        if (cool_cnt_q != '0 && bus.frame_tick) cool_cnt_d = cool_cnt_q - 1'b1;
      end
      default: active_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      cool_cnt_q <= '0;
      active_q   <= 1'b0;
      launched_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      cool_cnt_q <= cool_cnt_d;
      active_q   <= active_d;
      launched_q <= launched_d;
    end
  end

  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.active   = active_q;
  assign bus.launched = launched_q;

endmodule

// File: tb/tb_bullet_ctrl.sv
// Self-checking bench for bullet_ctrl: vector table, directed corner sequences
// and a randomized run against a behavioural model of the bullet.
module tb_bullet_ctrl;
  import game_pkg::*;

  localparam int R        = 12;
  localparam int SPEED    = 6;
  localparam int COOLDOWN = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bullet_ctrl_if bif ();

  bullet_ctrl #(.R(R), .SPEED(SPEED), .COOLDOWN(COOLDOWN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural bullet model
  bit m_live, m_cooling, m_launched, m_fire_prev;
  int m_x, m_y, m_frames_left;

  typedef struct {
    bit fire;
    bit tick;
    bit hit;
    int sx;
    int sy;
    bit e_active;
    bit e_launched;
    int e_x;
    int e_y;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_live = 0; m_cooling = 0; m_launched = 0; m_fire_prev = 0;
    m_x = 0; m_y = 0; m_frames_left = 0;
  endtask

  // Advance the model by one clock using the inputs currently on the bus.
  task automatic model_step();
    bit rise;
    rise = bif.fire && !m_fire_prev;
    m_launched = 0;
    if (m_live) begin
      if (bif.hit || (bif.frame_tick && (m_y - SPEED < R))) begin
        m_live = 0; m_cooling = 1; m_frames_left = COOLDOWN;
      end else if (bif.frame_tick) begin
        m_y = m_y - SPEED;
      end
    end else if (m_cooling) begin
      if (m_frames_left == 0) m_cooling = 0;
      else if (bif.frame_tick) m_frames_left--;
    end else if (rise) begin
      m_x = (int'(bif.shooter_x) >= H_ACTIVE) ? H_ACTIVE - 1 : int'(bif.shooter_x);
      m_y = (int'(bif.shooter_y) >= V_ACTIVE) ? V_ACTIVE - 1 : int'(bif.shooter_y);
      m_live = 1; m_launched = 1;
    end
    m_fire_prev = bif.fire;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit f, input bit t, input bit h);
    bif.fire = f; bif.frame_tick = t; bif.hit = h;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bif.frame_tick = 1; step();
      bif.frame_tick = 0; step();
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".active"},   int'(bif.active),   int'(m_live));
    check({tag, ".launched"}, int'(bif.launched), int'(m_launched));
    check({tag, ".x"},        int'(bif.x),        m_x);
    check({tag, ".y"},        int'(bif.y),        m_y);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int relaunches;
    int y_before;

    vecs[0] = '{0, 0, 0, 400, 550, 0, 0,   0,   0};
    vecs[1] = '{1, 0, 0, 400, 550, 1, 1, 400, 550};
    vecs[2] = '{1, 1, 0, 400, 550, 1, 0, 400, 544};
    vecs[3] = '{0, 0, 1, 400, 550, 0, 0, 400, 544};
    vecs[4] = '{1, 0, 0, 400, 550, 0, 0, 400, 544};
    vecs[5] = '{0, 1, 1, 400, 550, 0, 0, 400, 544};
    vecs[6] = '{1, 0, 0, 100, 100, 0, 0, 400, 544};
    vecs[7] = '{0, 1, 0, 100, 100, 0, 0, 400, 544};

    bif.shooter_x = '0;
    bif.shooter_y = '0;
    do_reset();
    check("reset.active",   int'(bif.active),   0);
    check("reset.launched", int'(bif.launched), 0);
    check("reset.x",        int'(bif.x),        0);
    check("reset.y",        int'(bif.y),        0);

    // Vector table
    foreach (vecs[i]) begin
      set_in(vecs[i].fire, vecs[i].tick, vecs[i].hit);
      bif.shooter_x = XW'(vecs[i].sx);
      bif.shooter_y = YW'(vecs[i].sy);
      step();
      check($sformatf("vec%0d.active", i),   int'(bif.active),   int'(vecs[i].e_active));
      check($sformatf("vec%0d.launched", i), int'(bif.launched), int'(vecs[i].e_launched));
      check($sformatf("vec%0d.x", i),        int'(bif.x),        vecs[i].e_x);
      check($sformatf("vec%0d.y", i),        int'(bif.y),        vecs[i].e_y);
    end

    // Launch and hold: no auto-repeat
    do_reset();
    bif.shooter_x = 11'd400; bif.shooter_y = 10'd550;
    set_in(1, 0, 0); step();
    check("launch.active",   int'(bif.active),   1);
    check("launch.launched", int'(bif.launched), 1);
    check("launch.x",        int'(bif.x),        400);
    check("launch.y",        int'(bif.y),        550);
    relaunches = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bif.launched) relaunches++;
    end
    check("hold.relaunches", relaunches, 0);

    // Motion: y moves only in the cycle after each tick
    for (int i = 1; i <= 10; i++) begin
      bif.frame_tick = 1; step();
      check($sformatf("motion%0d.y", i), int'(bif.y), 550 - SPEED * i);
      bif.frame_tick = 0; step();
      check($sformatf("motion%0d.hold_y", i), int'(bif.y), 550 - SPEED * i);
    end
    check("motion.x", int'(bif.x), 400);
    check("motion.active", int'(bif.active), 1);

    // Hit and tick together: treated as hit, y unchanged
    set_in(1, 1, 1); step();
    set_in(0, 0, 0);
    check("hit_tick.active", int'(bif.active), 0);
    check("hit_tick.y",      int'(bif.y),      490);

    // Cooldown: fire after 3 ticks ignored, launch after the 8th
    step();
    pulse_ticks(3);
    bif.fire = 1; step();
    check("cool_fire.active",   int'(bif.active),   0);
    check("cool_fire.launched", int'(bif.launched), 0);
    bif.fire = 0; step();
    pulse_ticks(5);
    step();
    bif.shooter_x = 11'd900; bif.shooter_y = 10'd700;
    bif.fire = 1; step();
    check("post_cool.launched", int'(bif.launched), 1);
    check("clamp.x", int'(bif.x), H_ACTIVE - 1);
    check("clamp.y", int'(bif.y), V_ACTIVE - 1);

    // Top edge: launch at y=20, retire on second tick without wrapping
    set_in(0, 0, 1); step();
    bif.hit = 0;
    pulse_ticks(8);
    step();
    bif.shooter_x = 11'd300; bif.shooter_y = 10'd20;
    bif.fire = 1; step();
    check("top.launch_y", int'(bif.y), 20);
    bif.fire = 0;
    pulse_ticks(1);
    check("top.tick1_y",      int'(bif.y),      14);
    check("top.tick1_active", int'(bif.active), 1);
    pulse_ticks(1);
    check("top.tick2_active", int'(bif.active), 0);
    check("top.tick2_y",      int'(bif.y),      14);
    pulse_ticks(3);
    check("top.no_wrap_y", int'(bif.y), 14);

    // Reset mid-flight: outputs drop without a clock edge
    pulse_ticks(6);
    step();
    bif.shooter_x = 11'd200; bif.shooter_y = 10'd300;
    bif.fire = 1; step();
    bif.fire = 0;
    pulse_ticks(1);
    check("prereset.y",      int'(bif.y),      294);
    check("prereset.active", int'(bif.active), 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst.active", int'(bif.active), 0);
    check("async_rst.x",      int'(bif.x),      0);
    check("async_rst.y",      int'(bif.y),      0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    bif.fire = 1; step();
    check("post_rst.launched", int'(bif.launched), 1);
    check("post_rst.x",        int'(bif.x),        200);
    check("post_rst.y",        int'(bif.y),        300);
    y_before = int'(bif.y);
    bif.fire = 0; step();
    check("post_rst.hold_y", int'(bif.y), y_before);

    // Randomized run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) bif.fire = ~bif.fire;
      bif.frame_tick = ($urandom_range(0, 5) == 0);
      bif.hit        = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) begin
        bif.shooter_x = XW'($urandom_range(0, 900));
        bif.shooter_y = YW'($urandom_range(0, 700));
      end
      step();
      check_model($sformatf("rand%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
